// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB completer in front of a LOCATION-deep, DATA-wide register file.
// Every transfer can be stretched by a fixed number of wait states, and an
// address at or above LOCATION gets an error response without touching
// storage.
//
// Ports:
//   PCLK       in   1        bus clock, all state changes on its rising edge
//   PRESETn    in   1        asynchronous active-low reset
//   PSEL       in   1        completer select
//   PENABLE    in   1        access-phase strobe
//   PWRITE     in   1        1 = write, 0 = read
//   PADDR      in   ADDRESS  transfer address
//   PWDATA     in   DATA     write data
//   PRDATA     out  DATA     read data, meaningful while PREADY=1 on a read
//   PREADY     out  1        transfer completes in the cycle this is high
//   PSLVERR    out  1        error response, meaningful while PREADY=1
//   state_dbg  out  2        current FSM state (0 idle, 1 wait, 2 ready)
//
// Handshake: a transfer opens with a setup cycle (PSEL=1, PENABLE=0), after
// which the requester holds PSEL=1, PENABLE=1 through the access phase. The
// transfer completes on the rising edge where PSEL, PENABLE and PREADY are
// all high. Dropping PSEL before that edge abandons the transfer.
// -----------------------------------------------------------------------------
module apb_slave_mem #(
    parameter int ADDRESS     = 8,
    parameter int DATA        = 8,
    parameter int LOCATION    = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [ADDRESS-1:0] PADDR,
    input  logic [DATA-1:0]    PWDATA,
    output logic [DATA-1:0]    PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    output logic [1:0]         state_dbg
);

    localparam int IDX_W = (LOCATION > 1) ? $clog2(LOCATION) : 1;

    // One extra bit so the range compare never truncates LOCATION.
    localparam logic [ADDRESS:0] LOC_LIM = LOCATION[ADDRESS:0];
    localparam logic [3:0]       WS_CNT  = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA-1:0]  mem [LOCATION];

    // Transfer context captured in the setup cycle
    logic [IDX_W-1:0] idx_q;
    logic [DATA-1:0]  wdata_q;
    logic             write_q;
    logic             err_q;
    logic [3:0]       cnt;

    logic             setup;
    logic             access;
    logic             addr_err;
    logic             err_cur;
    logic             wr_cur;
    logic [IDX_W-1:0] idx_cur;
    logic [DATA-1:0]  rd_word;
    logic             mem_we;

    logic [DATA-1:0]  prdata_d;
    logic             pready_d;
    logic             pslverr_d;

    assign setup    = PSEL && !PENABLE;
    assign access   = PSEL && PENABLE;
    assign addr_err = ({1'b0, PADDR} >= LOC_LIM);

    // With zero wait states READY is entered straight from the setup edge,
    // so the response must be built from the live bus rather than the
    // context registers, which are only loaded on that same edge.
    assign err_cur  = (state == S_IDLE) ? addr_err : err_q;
    assign wr_cur   = (state == S_IDLE) ? PWRITE : write_q;
    assign idx_cur  = (state == S_IDLE) ? PADDR[IDX_W-1:0] : idx_q;
    assign rd_word  = mem[idx_cur];

    assign mem_we    = (state == S_READY) && access && write_q && !err_q;
    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // PENABLE without a prior setup cycle is simply ignored here.
                if (setup) begin
                    state_nxt = (WAIT_STATES == 0) ? S_READY : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_nxt = S_IDLE;
                end else if (PENABLE && (cnt == 4'd1)) begin
                    // The edge that sees cnt==1 closes the last wait cycle.
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                // Either completion (PENABLE) or abort (PSEL dropped).
                if (!PSEL || PENABLE) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered response signals
    // -------------------------------------------------------------------------
    always_comb begin
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        if (state_nxt == S_READY) begin
            if (state == S_READY) begin
                prdata_d  = PRDATA;
                pready_d  = PREADY;
                pslverr_d = PSLVERR;
            end else begin
                pready_d  = 1'b1;
                pslverr_d = err_cur;
                if (!wr_cur && !err_cur) begin
                    prdata_d = rd_word;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs, transfer context, wait counter and storage
    // -------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= 4'd0;
            for (int i = 0; i < LOCATION; i++) begin
                mem[i] <= '0;
            end
        end else begin
            PRDATA  <= prdata_d;
            PREADY  <= pready_d;
            PSLVERR <= pslverr_d;

            if ((state == S_IDLE) && setup) begin
                idx_q   <= PADDR[IDX_W-1:0];
                wdata_q <= PWDATA;
                write_q <= PWRITE;
                err_q   <= addr_err;
                cnt     <= WS_CNT;
            end else if ((state == S_WAIT) && access) begin
                cnt <= cnt - 4'd1;
            end

            if (mem_we) begin
                mem[idx_q] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
//
// Three completers with 0, 2 and 3 wait states, each on its own bus.
// Directed vectors from a table, hand-built abort / reset sequences, then
// random transfers checked against a plain array model of the storage.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

    localparam int NDUT = 3;
    localparam int LOC  = 64;

    logic       clk;
    logic       rst_n;
    logic       psel    [NDUT];
    logic       penable [NDUT];
    logic       pwrite  [NDUT];
    logic [7:0] paddr   [NDUT];
    logic [7:0] pwdata  [NDUT];
    logic [7:0] prdata  [NDUT];
    logic       pready  [NDUT];
    logic       pslverr [NDUT];
    logic [1:0] st      [NDUT];

    int n_pass;
    int n_total;

    logic [7:0] mem_m [NDUT][LOC];

    typedef struct {
        int         idx;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        bit         exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb_slave_mem #(
            .ADDRESS    (8),
            .DATA       (8),
            .LOCATION   (LOC),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .PCLK      (clk),
            .PRESETn   (rst_n),
            .PSEL      (psel[g]),
            .PENABLE   (penable[g]),
            .PWRITE    (pwrite[g]),
            .PADDR     (paddr[g]),
            .PWDATA    (pwdata[g]),
            .PRDATA    (prdata[g]),
            .PREADY    (pready[g]),
            .PSLVERR   (pslverr[g]),
            .state_dbg (st[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NDUT; i++) begin
            for (int a = 0; a < LOC; a++) begin
                mem_m[i][a] = 8'h00;
            end
        end
    endtask

    task automatic bus_idle(input int i);
        psel[i]    = 1'b0;
        penable[i] = 1'b0;
        pwrite[i]  = 1'b0;
        paddr[i]   = 8'h00;
        pwdata[i]  = 8'h00;
    endtask

    // ---------------- driver ----------------
    // Entered and left at 1 time unit after a rising edge. The task drives
    // the bus to idle on return, so a following call starts its setup phase
    // in the very next cycle (back-to-back).
    task automatic xfer(input int i, input bit wr, input logic [7:0] addr,
                        input logic [7:0] data, output logic [7:0] rd,
                        output logic err, output int waits, output bit done);
        psel[i]    = 1'b1;
        penable[i] = 1'b0;
        pwrite[i]  = wr;
        paddr[i]   = addr;
        pwdata[i]  = data;
        @(posedge clk); #1;
        penable[i] = 1'b1;
        // The completer must use the values from the setup cycle.
        paddr[i]   = ~addr;
        pwdata[i]  = ~data;
        waits = 0;
        done  = 1'b0;
        rd    = 8'h00;
        err   = 1'b0;
        while (!done && waits < 20) begin
            @(negedge clk);
            if (pready[i]) begin
                done = 1'b1;
                rd   = prdata[i];
                err  = pslverr[i];
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        bus_idle(i);
    endtask

    // Transfer checked against the storage model.
    task automatic run_xfer(input int i, input bit wr, input logic [7:0] addr,
                            input logic [7:0] data, input string tag);
        logic [7:0] rd;
        logic       err;
        int         waits;
        bit         done;
        bit         exp_err;
        logic [7:0] exp_rd;
        exp_err = (int'(addr) >= LOC);
        exp_rd  = exp_err ? 8'h00 : mem_m[i][addr[5:0]];
        xfer(i, wr, addr, data, rd, err, waits, done);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_waits"}, 32'(waits), 32'(ws_of(i)));
        chk({tag, "_pslverr"}, 32'(err), 32'(exp_err));
        if (!wr) begin
            chk({tag, "_prdata"}, 32'(rd), 32'(exp_rd));
        end else if (!exp_err) begin
            mem_m[i][addr[5:0]] = data;
        end
    endtask

    // Start a read on the zero-wait completer, then pull reset in the middle
    // of the cycle where PREADY is high.
    task automatic rst_in_ready(input logic [7:0] addr, input logic [7:0] exp_rd,
                                input bit exp_err, input string tag);
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        pwrite[0]  = 1'b0;
        paddr[0]   = addr;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(negedge clk);
        chk({tag, "_pre_pready"}, 32'(pready[0]), 32'd1);
        chk({tag, "_pre_prdata"}, 32'(prdata[0]), 32'(exp_rd));
        chk({tag, "_pre_pslverr"}, 32'(pslverr[0]), 32'(exp_err));
        #2;
        rst_n = 1'b0;
        bus_idle(0);
        #1;
        chk({tag, "_rst_pready"}, 32'(pready[0]), 32'd0);
        chk({tag, "_rst_prdata"}, 32'(prdata[0]), 32'd0);
        chk({tag, "_rst_pslverr"}, 32'(pslverr[0]), 32'd0);
        model_clear();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [7:0] rd;
        logic       err;
        int         waits;
        bit         done;
        bit         seen;

        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < NDUT; i++) bus_idle(i);
        model_clear();

        // idx, wr, addr, data, exp_err, exp_rd
        vecs[0]  = '{0, 1'b1, 8'd2,   8'd6,   1'b0, 8'd0};
        vecs[1]  = '{0, 1'b0, 8'd2,   8'd0,   1'b0, 8'd6};
        vecs[2]  = '{0, 1'b1, 8'd70,  8'd5,   1'b1, 8'd0};
        vecs[3]  = '{0, 1'b0, 8'd70,  8'd0,   1'b1, 8'd0};
        vecs[4]  = '{0, 1'b0, 8'd6,   8'd0,   1'b0, 8'd0};
        vecs[5]  = '{0, 1'b1, 8'd15,  8'd3,   1'b0, 8'd0};
        vecs[6]  = '{0, 1'b0, 8'd15,  8'd0,   1'b0, 8'd3};
        vecs[7]  = '{0, 1'b1, 8'd63,  8'hA5,  1'b0, 8'd0};
        vecs[8]  = '{0, 1'b0, 8'd63,  8'd0,   1'b0, 8'hA5};
        vecs[9]  = '{0, 1'b1, 8'd64,  8'h11,  1'b1, 8'd0};
        vecs[10] = '{0, 1'b0, 8'd0,   8'd0,   1'b0, 8'd0};
        vecs[11] = '{0, 1'b0, 8'd255, 8'd0,   1'b1, 8'd0};
        vecs[12] = '{2, 1'b1, 8'd16,  8'd98,  1'b0, 8'd0};
        vecs[13] = '{2, 1'b0, 8'd16,  8'd0,   1'b0, 8'd98};
        vecs[14] = '{1, 1'b0, 8'd16,  8'd0,   1'b0, 8'd0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("reset%0d_pready", i), 32'(pready[i]), 32'd0);
            chk($sformatf("reset%0d_pslverr", i), 32'(pslverr[i]), 32'd0);
            chk($sformatf("reset%0d_prdata", i), 32'(prdata[i]), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int k = 0; k < NVEC; k++) begin
            xfer(vecs[k].idx, vecs[k].wr, vecs[k].addr, vecs[k].data, rd, err, waits, done);
            chk($sformatf("vec%0d_done", k), 32'(done), 32'd1);
            chk($sformatf("vec%0d_waits", k), 32'(waits), 32'(ws_of(vecs[k].idx)));
            chk($sformatf("vec%0d_pslverr", k), 32'(err), 32'(vecs[k].exp_err));
            if (!vecs[k].wr) begin
                chk($sformatf("vec%0d_prdata", k), 32'(rd), 32'(vecs[k].exp_rd));
            end else if (!vecs[k].exp_err) begin
                mem_m[vecs[k].idx][vecs[k].addr[5:0]] = vecs[k].data;
            end
        end

        // Abort: 2-wait completer, write 20<-63, PSEL dropped after one access cycle
        psel[1]    = 1'b1;
        penable[1] = 1'b0;
        pwrite[1]  = 1'b1;
        paddr[1]   = 8'd20;
        pwdata[1]  = 8'd63;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(negedge clk);
        chk("abort_first_access_pready", 32'(pready[1]), 32'd0);
        @(posedge clk); #1;
        bus_idle(1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (pready[1]) seen = 1'b1;
        end
        @(posedge clk); #1;
        chk("abort_pready_never", 32'(seen), 32'd0);
        run_xfer(1, 1'b0, 8'd20, 8'd0, "abort_readback");

        // Async reset during a wait-state write to addr 5 on the 3-wait completer
        run_xfer(2, 1'b1, 8'd5, 8'h5A, "rstw_prewrite");
        psel[2]    = 1'b1;
        penable[2] = 1'b0;
        pwrite[2]  = 1'b1;
        paddr[2]   = 8'd5;
        pwdata[2]  = 8'h33;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        bus_idle(2);
        #1;
        chk("rstw_pready", 32'(pready[2]), 32'd0);
        chk("rstw_pslverr", 32'(pslverr[2]), 32'd0);
        chk("rstw_prdata", 32'(prdata[2]), 32'd0);
        model_clear();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_xfer(2, 1'b0, 8'd5, 8'd0, "rstw_read5");
        run_xfer(0, 1'b0, 8'd2, 8'd0, "rstw_cleared2");

        // Async reset while PREADY is high: registered outputs drop before the next edge
        run_xfer(0, 1'b1, 8'd9, 8'hC3, "rstr_prewrite");
        rst_in_ready(8'd9, 8'hC3, 1'b0, "rstr_read9");
        rst_in_ready(8'd70, 8'h00, 1'b1, "rstr_read70");
        run_xfer(0, 1'b0, 8'd9, 8'd0, "rstr_cleared9");

        // Random traffic against the model
        for (int n = 0; n < 150; n++) begin
            int         i;
            bit         wr;
            logic [7:0] a;
            logic [7:0] d;
            i  = int'($urandom_range(0, NDUT - 1));
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 79));
            d  = 8'($urandom);
            run_xfer(i, wr, a, d, $sformatf("rand%0d", n));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
